// File: rtl/seq_alu_if.sv
// ----------------------------------------------------------------------------
// SeqAluIf -- operation bus between a requester and the sequential ALU.
//
// Parameter:
//    N       operand/result width in bits
//
// Signals:
//    start   requester -> ALU   operation request, sampled on rising clk
//    ALUSEL  requester -> ALU   3-bit opcode
//    AC      requester -> ALU   operand A (accumulator)
//    AR      requester -> ALU   operand B
//    q       ALU -> requester   registered result
//    done    ALU -> requester   one-cycle completion pulse
//    busy    ALU -> requester   multi-cycle operation in progress
//    C       ALU -> requester   carry/borrow/shift-out/overflow flag
//    Z       ALU -> requester   result-is-zero flag
//
// Modports:
//    master  the requester side (drives start/ALUSEL/AC/AR)
//    slave   the ALU side (drives q/done/busy/C/Z)
// ----------------------------------------------------------------------------
interface seq_alu_if #(
   parameter int N = 8
) ();

   logic          start;
   logic [2:0]    ALUSEL;
   logic [N-1:0]  AC;
   logic [N-1:0]  AR;
   logic [N-1:0]  q;
   logic          done;
   logic          busy;
   logic          C;
   logic          Z;

   modport master (
      output start, ALUSEL, AC, AR,
      input  q, done, busy, C, Z
   );

   modport slave (
      input  start, ALUSEL, AC, AR,
      output q, done, busy, C, Z
   );

endinterface

// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu -- sequential ALU with single-cycle logic/arithmetic/shift ops and
// an optional multi-cycle shift-add multiplier.
//
// Parameter:
//    N       operand/result width in bits (N >= 4)
//
// Ports:
//    clk     single clock, all state updates on the rising edge
//    rst_n   asynchronous active-low reset
//    bus     seq_alu_if.slave: start/ALUSEL/AC/AR in, q/done/busy/C/Z out
//
// Opcodes (ALUSEL):
//    000 ADD  001 AND  010 SUB  011 OR  100 XOR  101 SHL  110 SHR  111 MUL
//
// Configuration macro:
//    SEQ_ALU_MUL_EN  when defined, opcode 111 is an N-cycle unsigned multiply
//                    (IDLE -> MULT -> IDLE). When undefined, no multiplier
//                    state is built and opcode 111 is a one-cycle pass of AC
//                    with C = 0; busy is then constantly 0.
// ----------------------------------------------------------------------------
module seq_alu #(
   parameter int N = 8
) (
   input logic    clk,
   input logic    rst_n,
   seq_alu_if.slave bus
);

   localparam int SW = $clog2(N);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   // Registered outputs shared by both builds
   logic [N-1:0]  result_q;
   logic          carry_q;
   logic          zero_q;
   logic          done_q;

   // Single-cycle result computed straight from the bus operands so it can be
   // written on the accepting edge
   logic [N-1:0]  result_d;
   logic          carry_d;
   logic [N:0]    sumExt;
   logic [SW-1:0] shamt;
   logic [2*N-1:0] shlExt;
   logic [2*N-1:0] shrExt;

`ifdef SEQ_ALU_MUL_EN
   typedef enum logic {
      IDLE = 1'b0,
      MULT = 1'b1
   } state_t;

   state_t          state_q;
   logic [2*N-1:0]  acc_q;
   logic [2*N-1:0]  mcand_q;
   logic [N-1:0]    mplier_q;
   logic [SW-1:0]   count_q;
   logic [2*N-1:0]  acc_d;
   logic [N-1:0]    product_d;
   logic            overflow_d;
`endif

   // Combinational datapath for the one-cycle opcodes. Shifts are done on a
   // double-width vector so the last bit shifted out lands at a fixed
   // position (bit N for SHL, bit N-1 for SHR); a zero shift leaves that
   // position 0, which gives C = 0 for free.
   always_comb begin
      result_d = bus.AC;
      carry_d  = 1'b0;
      sumExt   = {1'b0, bus.AC} + {1'b0, bus.AR};
      shamt    = bus.AR[SW-1:0];
      shlExt   = {{N{1'b0}}, bus.AC} << shamt;
      shrExt   = {bus.AC, {N{1'b0}}} >> shamt;
      unique case (bus.ALUSEL)
         OP_ADD: begin
            result_d = sumExt[N-1:0];
            carry_d  = sumExt[N];
         end
         OP_AND: result_d = bus.AC & bus.AR;
         OP_SUB: begin
            result_d = bus.AC - bus.AR;
            carry_d  = (bus.AC < bus.AR);
         end
         OP_OR:  result_d = bus.AC | bus.AR;
         OP_XOR: result_d = bus.AC ^ bus.AR;
         OP_SHL: begin
            result_d = shlExt[N-1:0];
            carry_d  = shlExt[N];
         end
         OP_SHR: begin
            result_d = shrExt[2*N-1:N];
            carry_d  = shrExt[N-1];
         end
         OP_MUL: begin
            result_d = bus.AC;
            carry_d  = 1'b0;
         end
         default: begin
            result_d = bus.AC;
            carry_d  = 1'b0;
         end
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   // One shift-add step of the multiplier: add the (pre-shifted)
   // multiplicand when the current multiplier LSB is set. On the final step
   // this sum is the full 2N-bit product.
   always_comb begin
      acc_d      = acc_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});
      product_d  = acc_d[N-1:0];
      overflow_d = |acc_d[2*N-1:N];
   end
`endif

   // Control FSM and all output registers. A request is only looked at in
   // IDLE, so starts during MULT fall on the floor and the in-flight
   // operands live in the multiplier registers, not on the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.ALUSEL == OP_MUL) begin
                     acc_q    <= '0;
                     mcand_q  <= {{N{1'b0}}, bus.AC};
                     mplier_q <= bus.AR;
                     count_q  <= '0;
                     state_q  <= MULT;
                  end else begin
                     result_q <= result_d;
                     carry_q  <= carry_d;
                     zero_q   <= (result_d == '0);
                     done_q   <= 1'b1;
                  end
               end
            end
            MULT: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + 1'b1;
               // The N-th step after acceptance retires the product
               if (count_q == SW'(N - 1)) begin
                  result_q <= product_d;
                  carry_q  <= overflow_d;
                  zero_q   <= (product_d == '0);
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
`else
         if (bus.start) begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= (result_d == '0);
            done_q   <= 1'b1;
         end
`endif
      end
   end

   // Output wiring; busy is a pure decode of the state register
   assign bus.q    = result_q;
   assign bus.C    = carry_q;
   assign bus.Z    = zero_q;
   assign bus.done = done_q;
`ifdef SEQ_ALU_MUL_EN
   assign bus.busy = (state_q == MULT);
`else
   assign bus.busy = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu -- scoreboard bench for seq_alu (N = 8).
// The driver issues requests on the falling edge and, for every request the
// ALU should accept, pushes the expected result and completion edge into a
// queue. An independent monitor samples 1 time unit after each rising edge,
// pops on done and compares; it also checks busy and that outputs hold
// between completions.
// ----------------------------------------------------------------------------
module tb_seq_alu;

   localparam int N = 8;

   typedef struct {
      int q;
      bit c;
      bit z;
      int atEdge;
   } exp_t;

   logic clk;
   logic rst_n;

   seq_alu_if #(.N(N)) bus ();

   seq_alu #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   exp_t expQ[$];
   int   checks   = 0;
   int   errors   = 0;
   int   edgeCount = 0;
   int   busyEnd  = 0;
   int   mulStart = 0;
   int   mulEnd   = 0;
   int   holdQ    = 0;
   bit   holdC    = 0;
   bit   holdZ    = 1;

   // Free-running clock, first rising edge at 5
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counted, and reported when it disagrees
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Behavioural reference: plain integer arithmetic from the opcode rules
   function automatic void refModel(input int op, input int a, input int b,
                                    output int q, output bit c);
      int sh;
      int p;
      sh = b % N;
      q  = 0;
      c  = 0;
      case (op)
         0: begin p = a + b; q = p % 256; c = (p >= 256); end
         1: q = a & b;
         2: begin q = (a - b + 256) % 256; c = (a < b); end
         3: q = a | b;
         4: q = a ^ b;
         5: begin q = (a << sh) % 256; c = (sh == 0) ? 0 : ((a >> (N - sh)) & 1); end
         6: begin q = a >> sh; c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1); end
         default: begin
`ifdef SEQ_ALU_MUL_EN
            p = a * b;
            q = p % 256;
            c = (p >= 256);
`else
            q = a;
            c = 0;
`endif
         end
      endcase
   endfunction

   // Drive one cycle of inputs (caller is already at a falling edge) and
   // predict whether the upcoming rising edge accepts it
   task automatic issue(input bit st, input int op, input int a, input int b);
      int   e;
      exp_t x;
      int   rq;
      bit   rc;
      bus.start  = st;
      bus.ALUSEL = 3'(op);
      bus.AC     = 8'(a);
      bus.AR     = 8'(b);
      e = edgeCount + 1;
      if (st && e > busyEnd) begin
         refModel(op, a, b, rq, rc);
         x.q = rq;
         x.c = rc;
         x.z = (rq == 0);
`ifdef SEQ_ALU_MUL_EN
         if (op == 7) begin
            x.atEdge = e + N;
            mulStart = e;
            mulEnd   = e + N;
         end else begin
            x.atEdge = e;
         end
`else
         x.atEdge = e;
`endif
         busyEnd = x.atEdge;
         expQ.push_back(x);
      end
   endtask

   task automatic applyStimulus(input bit st, input int op, input int a, input int b);
      @(negedge clk);
      issue(st, op, a, b);
   endtask

   // Assert reset mid-cycle, check the immediate effect, then clear the model
   task automatic applyReset(input int cyclesLow);
      @(negedge clk);
      rst_n     = 1'b0;
      bus.start = 1'b0;
      #1;
      checkOutput("rst_q", int'(bus.q), 0);
      checkOutput("rst_C", int'(bus.C), 0);
      checkOutput("rst_Z", int'(bus.Z), 1);
      checkOutput("rst_done", int'(bus.done), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      expQ.delete();
      holdQ    = 0;
      holdC    = 0;
      holdZ    = 1;
      mulStart = 0;
      mulEnd   = 0;
      repeat (cyclesLow) @(negedge clk);
      busyEnd = edgeCount;
   endtask

   // Monitor: compare on done, otherwise expect held outputs
   initial begin
      exp_t x;
      int   busyExp;
      forever begin
         @(posedge clk);
         edgeCount++;
         #1;
         busyExp = (edgeCount >= mulStart && edgeCount < mulEnd) ? 1 : 0;
         checkOutput("busy", int'(bus.busy), busyExp);
         if (bus.done === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               x = expQ.pop_front();
               checkOutput("done_edge", edgeCount, x.atEdge);
               checkOutput("q", int'(bus.q), x.q);
               checkOutput("C", int'(bus.C), int'(x.c));
               checkOutput("Z", int'(bus.Z), int'(x.z));
               holdQ = x.q;
               holdC = x.c;
               holdZ = x.z;
            end
         end else begin
            if (expQ.size() > 0 && expQ[0].atEdge <= edgeCount) begin
               x = expQ.pop_front();
               checkOutput("missing_done", 0, 1);
            end
            checkOutput("hold_q", int'(bus.q), holdQ);
            checkOutput("hold_C", int'(bus.C), int'(holdC));
            checkOutput("hold_Z", int'(bus.Z), int'(holdZ));
         end
      end
   end

   // Driver: directed vectors, random traffic, reset mid-operation, drain
   initial begin
      int guard;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.ALUSEL = 3'b000;
      bus.AC     = '0;
      bus.AR     = '0;
      repeat (3) @(negedge clk);
      checkOutput("init_q", int'(bus.q), 0);
      checkOutput("init_C", int'(bus.C), 0);
      checkOutput("init_Z", int'(bus.Z), 1);
      checkOutput("init_done", int'(bus.done), 0);
      checkOutput("init_busy", int'(bus.busy), 0);
      rst_n   = 1'b1;
      busyEnd = edgeCount;

      // Directed: ADD, back-to-back AND/SUB, shifts, MUL with ignored starts
      applyStimulus(1, 0, 20, 30);
      applyStimulus(1, 1, 20, 30);
      applyStimulus(1, 2, 20, 30);
      applyStimulus(1, 5, 8'h81, 1);
      applyStimulus(1, 6, 8'h81, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 7, 12, 13);
      applyStimulus(1, 0, 99, 99);
      applyStimulus(1, 4, 55, 77);
      applyStimulus(1, 7, 3, 3);
      repeat (N) applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 7, 20, 30);
      applyStimulus(1, 7, 7, 0);

      // Random traffic; operand changes while busy must not disturb results
      for (int i = 0; i < 300; i++) begin
         applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      guard = 0;
      while (edgeCount < busyEnd && guard < 4 * N) begin
         applyStimulus(0, 0, 0, 0);
         guard++;
      end

      // Reset four cycles into a multiply, then ADD on the first edge after
      applyStimulus(1, 7, 200, 201);
      repeat (3) applyStimulus(0, 0, 0, 0);
      applyReset(2);
      rst_n = 1'b1;
      issue(1, 0, 1, 255);
      applyStimulus(0, 0, 0, 0);

      // Drain, bounded
      guard = 0;
      while (expQ.size() > 0 && guard < 4 * N) begin
         applyStimulus(0, 0, 0, 0);
         guard++;
      end
      applyStimulus(0, 0, 0, 0);
      if (expQ.size() > 0) checkOutput("drain_timeout", expQ.size(), 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits; SHALL support N >= 4.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  operation request, sampled on rising clk.
REQ-005 Port: ALUSEL  in  3  opcode: 000 ADD, 001 AND, 010 SUB, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-006 Port: AC  in  N  operand A (accumulator).
REQ-007 Port: AR  in  N  operand B.
REQ-008 Port: q  out  N  registered result, held until next completion.
REQ-009 Port: done  out  1  one-cycle pulse; q/C/Z updated on the same edge.
REQ-010 Port: busy  out  1  high while a multi-cycle operation is in progress.
REQ-011 Port: C  out  1  carry/borrow/shift-out/overflow flag, registered.
REQ-012 Port: Z  out  1  high when q == 0, registered.

Function
REQ-013 FSM states SHALL be IDLE and MULT; busy SHALL equal (state == MULT).
REQ-014 In IDLE, start=1 SHALL latch ALUSEL, AC and AR on that edge.
REQ-015 Single-cycle ops (000-110) SHALL update q, C, Z and pulse done on the accepting edge (latency 1), with the FSM remaining in IDLE.
REQ-016 ADD: q = (AC+AR) mod 2^N; C = carry out of bit N-1.
REQ-017 SUB: q = (AC-AR) mod 2^N; C = 1 if AC < AR (borrow), unsigned.
REQ-018 AND/OR/XOR: bitwise; C = 0.
REQ-019 SHL/SHR: logical shift of AC by AR[clog2(N)-1:0]; C = last bit shifted out, 0 when the shift amount is 0.
REQ-020 MUL: accepting edge -> MULT; shift-add over one multiplier bit per cycle with a 2N-bit accumulator and a bit counter.
REQ-021 MUL SHALL complete exactly N cycles after the accepting edge: q = product[N-1:0], C = |product[2N-1:N], done pulses, FSM returns to IDLE.
REQ-022 start while busy=1 SHALL be ignored; in-flight operands SHALL be unaffected by input changes.
REQ-023 start in IDLE on the edge where done was just pulsed SHALL be accepted (back-to-back issue, no bubble).
REQ-024 done SHALL be 0 on every cycle without a completion; q, C and Z SHALL hold between completions.
REQ-025 Z SHALL be computed from the new q value on each completion.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, q=0, C=0, Z=1, done=0, busy=0, and clear the accumulator and counter.
REQ-027 Reset during MULT SHALL abort the operation with no done pulse; the first edge after release SHALL accept a new start.

Configuration
REQ-028 Macro SEQ_ALU_MUL_EN: when defined, opcode 111 SHALL behave per REQ-020/021.
REQ-029 Without SEQ_ALU_MUL_EN: no MULT state or accumulator SHALL be built; opcode 111 SHALL complete in 1 cycle with q=AC, C=0, and busy SHALL stay 0.

Verification
REQ-030 ADD, N=8: AC=20, AR=30, start -> next edge q=50, C=0, Z=0, done=1 for one cycle.
REQ-031 AND then SUB, N=8: AC=20, AR=30 -> AND q=8'b00010100 (20); SUB q=246, C=1; issued back-to-back -> two consecutive done pulses.
REQ-032 SHL, N=8: AC=8'h81, AR=1 -> q=8'h02, C=1; SHR AC=8'h81, AR=0 -> q=8'h81, C=0.
REQ-033 MUL with macro, N=8: AC=12, AR=13 -> busy=1 for 8 cycles, q=156, C=0, done at edge 8; AC=20, AR=30 -> q=88, C=1; start pulses while busy are ignored.
REQ-034 Reset mid-MUL: assert rst_n=0 at cycle 4 of MUL -> q=0, Z=1, busy=0 immediately, no done; after release, ADD 1+255 -> q=0, C=1, Z=1.
REQ-035 Without the macro: ALUSEL=111, AC=7 -> next edge q=7, C=0, done=1, busy never high.
